// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: ISA encodings, FSM states,
// ALU operations and the instruction legality/decoding helpers.
package mc_cpu_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [31:0] HALT_INSN = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_ALUWB,
        S_MEMWB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    // HALT_INSN carries opcode 0x3F, so it falls out as illegal along with every unlisted encoding.
    function automatic logic insn_legal(input logic [31:0] insn);
        logic [5:0] op;
        logic [5:0] fn;
        op = insn[31:26];
        fn = insn[5:0];
        if (insn == HALT_INSN) begin
            return 1'b0;
        end
        case (op)
            OP_RTYPE: return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                             (fn == FN_OR)  || (fn == FN_SLT);
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic alu_op_t alu_op_for(input logic [31:0] insn);
        if (insn[31:26] != OP_RTYPE) begin
            return ALU_ADD;
        end
        case (insn[5:0])
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32-entry register file: two asynchronous read ports, one synchronous write port, $0 hardwired to zero.
module mc_regfile
    import mc_cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] ra,
    input  logic [REG_AW-1:0] rb,
    output logic [XLEN-1:0]   rdata_a,
    output logic [XLEN-1:0]   rdata_b,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata
);

    logic [XLEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (ra == '0) ? '0 : regs[ra];
    assign rdata_b = (rb == '0) ? '0 : regs[rb];

endmodule

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: one shared datapath sequenced FETCH/DECODE/EXEC/MEM/WB
// over a single req/ready memory port that tolerates wait states.
module multi_cycle_cpu
    import mc_cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              AW       = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            retire,
    output logic [XLEN-1:0] pc_dbg,
    output logic            halted
);

    // Keeps every PC computation inside the AW-bit byte address space.
    localparam logic [XLEN-1:0] AW_MASK = {XLEN{1'b1}} >> (XLEN - AW);

    state_t state;

    logic [31:0]     ir;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] a_val;
    logic [XLEN-1:0] b_val;
    logic [XLEN-1:0] t_val;
    logic [XLEN-1:0] y_val;
    logic [XLEN-1:0] mdr;

    logic [5:0]             opcode;
    logic [REG_AW-1:0]      rs;
    logic [REG_AW-1:0]      rt;
    logic [REG_AW-1:0]      rd;
    logic signed [XLEN-1:0] imm_sext;

    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jump_target;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_y;
    logic [XLEN-1:0] addr_sum;

    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;

    function automatic logic [XLEN-1:0] alu(input alu_op_t op,
                                            input logic signed [XLEN-1:0] x,
                                            input logic signed [XLEN-1:0] y);
        case (op)
            ALU_SUB: return x - y;
            ALU_AND: return x & y;
            ALU_OR:  return x | y;
            ALU_SLT: return (x < y) ? XLEN'(1) : '0;
            default: return x + y;
        endcase
    endfunction

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign imm_sext = {{(XLEN-16){ir[15]}}, ir[15:0]};

    // pc already holds PC+4 once FETCH completes, so the branch base is implicit.
    assign pc_plus4    = (pc + XLEN'(4)) & AW_MASK;
    assign br_target   = (pc + {imm_sext[XLEN-3:0], 2'b00}) & AW_MASK;
    assign jump_target = {pc[XLEN-1:28], ir[25:0], 2'b00} & AW_MASK;
    assign alu_b       = (opcode == OP_ADDI) ? imm_sext : b_val;
    assign alu_y       = alu(alu_op_for(ir), a_val, alu_b);
    assign addr_sum    = a_val + imm_sext;

    assign mem_addr  = (state == S_MEM) ? y_val[AW-1:0] : pc[AW-1:0];
    assign mem_wdata = b_val;
    assign pc_dbg    = pc;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rt;
        rf_wdata = y_val;
        case (state)
            S_ALUWB: begin
                rf_we    = 1'b1;
                rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
            end
            S_MEMWB: begin
                rf_we    = 1'b1;
                rf_wdata = mdr;
            end
            default: ;
        endcase
    end

    mc_regfile #(.XLEN(XLEN)) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .ra      (rs),
        .rb      (rt),
        .rdata_a (rs_data),
        .rdata_b (rt_data),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata)
    );

    // mem_req is raised on the edge entering FETCH/MEM and dropped on the transfer edge,
    // so address/data are held by the unchanging pc/y_val/b_val while waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            pc      <= RESET_PC & AW_MASK;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            retire  <= 1'b0;
            halted  <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                    end else if (mem_ready) begin
                        ir      <= mem_rdata[31:0];
                        pc      <= pc_plus4;
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_val <= rs_data;
                    b_val <= rt_data;
                    t_val <= br_target;
                    if (!insn_legal(ir)) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (opcode == OP_J) begin
                        pc      <= jump_target;
                        retire  <= 1'b1;
                        mem_req <= 1'b1;
                        state   <= S_FETCH;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (opcode)
                        OP_RTYPE, OP_ADDI: begin
                            y_val <= alu_y;
                            state <= S_ALUWB;
                        end
                        OP_LW, OP_SW: begin
                            y_val <= addr_sum;
                            if (addr_sum[1:0] != 2'b00) begin
                                halted <= 1'b1;
                                state  <= S_HALT;
                            end else begin
                                mem_req <= 1'b1;
                                mem_we  <= (opcode == OP_SW);
                                state   <= S_MEM;
                            end
                        end
                        OP_BEQ: begin
                            if (a_val == b_val) begin
                                pc <= t_val;
                            end
                            retire  <= 1'b1;
                            mem_req <= 1'b1;
                            state   <= S_FETCH;
                        end
                        default: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        mem_we <= 1'b0;
                        if (mem_we) begin
                            retire  <= 1'b1;
                            mem_req <= 1'b1;
                            state   <= S_FETCH;
                        end else begin
                            mdr     <= mem_rdata;
                            mem_req <= 1'b0;
                            state   <= S_MEMWB;
                        end
                    end
                end
                S_ALUWB, S_MEMWB: begin
                    retire  <= 1'b1;
                    mem_req <= 1'b1;
                    state   <= S_FETCH;
                end
                default: begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    halted  <= 1'b1;
                    state   <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Bench for multi_cycle_cpu: wait-state memory model, store scoreboard, ALU vector table
// and hand-written branch/halt/reset sequences.
module tb_multi_cycle_cpu;

    localparam logic [5:0] T_ADDI = 6'h08, T_LW = 6'h23, T_SW = 6'h2B, T_BEQ = 6'h04;
    localparam logic [5:0] T_ADD = 6'h20, T_SUB = 6'h22, T_AND = 6'h24, T_OR = 6'h25, T_SLT = 6'h2A;
    localparam logic [31:0] T_HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, retire, halted;
    logic [31:0] mem_addr, mem_wdata, pc_dbg;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    multi_cycle_cpu #(.XLEN(32), .AW(32), .RESET_PC(32'h0)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .retire    (retire),
        .pc_dbg    (pc_dbg),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } store_t;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] insn;
        logic [31:0] expect_val;
    } vec_t;

    logic [31:0] mem [1024];
    store_t      exp_q[$];
    int          retire_cyc[$];
    logic [31:0] retire_pc[$];
    int n_vec = 0, n_err = 0;
    int cyc = 0, wcnt = 0, xfers = 0, fetch_waits = 0, data_waits = 0;
    bit granted = 0, next_fetch = 1, prev_pending = 0;
    logic        prev_we;
    logic [31:0] prev_addr, prev_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_insn(input logic [5:0] fn, input logic [4:0] rd,
                                           input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_insn(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_insn(input logic [25:0] idx);
        return {6'h02, idx};
    endfunction

    // Memory model, hold checker, store scoreboard and retire recorder in one process.
    always @(negedge clk) begin
        cyc++;
        if (granted) begin
            wcnt    = 0;
            granted = 0;
        end
        if (reset) begin
            wcnt         = 0;
            next_fetch   = 1;
            prev_pending = 0;
            mem_ready    = 1'b1;
        end else begin
            if (retire) begin
                retire_cyc.push_back(cyc);
                retire_pc.push_back(pc_dbg);
                next_fetch = 1;
            end
            if (prev_pending) begin
                check("hold_req", {31'b0, mem_req}, 32'd1);
                check("hold_we", {31'b0, mem_we}, {31'b0, prev_we});
                check("hold_addr", mem_addr, prev_addr);
                if (prev_we) check("hold_wdata", mem_wdata, prev_wdata);
            end
            if (mem_req) begin
                if (wcnt >= (next_fetch ? fetch_waits : data_waits)) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr[11:2]];
                    if (mem_we) begin
                        if (exp_q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected_store: addr %h data %h, none expected",
                                     mem_addr, mem_wdata);
                        end else begin
                            store_t s;
                            s = exp_q.pop_front();
                            check("store_addr", mem_addr, s.addr);
                            check("store_data", mem_wdata, s.data);
                        end
                        mem[mem_addr[11:2]] = mem_wdata;
                    end
                    granted    = 1;
                    next_fetch = 0;
                    xfers++;
                end else begin
                    mem_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                // ready chatters high while idle; the core must ignore it
                mem_ready = 1'b1;
                wcnt      = 0;
            end
            prev_pending = mem_req && !granted;
            prev_we      = mem_we;
            prev_addr    = mem_addr;
            prev_wdata   = mem_wdata;
        end
    end

    task automatic apply_reset(input string tag);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_rst_req"}, {31'b0, mem_req}, 32'd0);
        check({tag, "_rst_we"}, {31'b0, mem_we}, 32'd0);
        check({tag, "_rst_pc"}, pc_dbg, 32'h0);
        check({tag, "_rst_halted"}, {31'b0, halted}, 32'd0);
        check({tag, "_rst_retire"}, {31'b0, retire}, 32'd0);
        retire_cyc.delete();
        retire_pc.delete();
        exp_q.delete();
        xfers = 0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
    endtask

    task automatic release_reset();
        #1 reset = 1'b0;
    endtask

    task automatic run_until_halt(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && !halted; i++) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_halt_reached"}, {31'b0, halted}, 32'd1);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    function automatic int interval(input int i);
        if (i + 1 < retire_cyc.size()) return retire_cyc[i+1] - retire_cyc[i];
        return 0;
    endfunction

    vec_t vecs[13];
    int   seq1_int[9];
    logic [31:0] seq3_pc[7];
    int   seq3_int[6];
    logic [31:0] bad_insn[3];
    string bad_name[3];

    initial begin
        vecs[0]  = '{"add_wrap",   32'h7FFF_FFFF, 32'h0000_0001, r_insn(T_ADD, 3, 1, 2), 32'h8000_0000};
        vecs[1]  = '{"add_carry",  32'hFFFF_FFFF, 32'h0000_0001, r_insn(T_ADD, 3, 1, 2), 32'h0000_0000};
        vecs[2]  = '{"sub_borrow", 32'h0000_0000, 32'h0000_0001, r_insn(T_SUB, 3, 1, 2), 32'hFFFF_FFFF};
        vecs[3]  = '{"sub_neg",    32'h0000_0005, 32'h0000_0008, r_insn(T_SUB, 3, 1, 2), 32'hFFFF_FFFD};
        vecs[4]  = '{"and",        32'hF0F0_1234, 32'h0FF0_FF00, r_insn(T_AND, 3, 1, 2), 32'h00F0_1200};
        vecs[5]  = '{"or",         32'hF0F0_0000, 32'h0000_0F0F, r_insn(T_OR,  3, 1, 2), 32'hF0F0_0F0F};
        vecs[6]  = '{"slt_neg",    32'hFFFF_FFFD, 32'h0000_0005, r_insn(T_SLT, 3, 1, 2), 32'h0000_0001};
        vecs[7]  = '{"slt_pos",    32'h0000_0005, 32'hFFFF_FFFD, r_insn(T_SLT, 3, 1, 2), 32'h0000_0000};
        vecs[8]  = '{"slt_min",    32'h8000_0000, 32'h7FFF_FFFF, r_insn(T_SLT, 3, 1, 2), 32'h0000_0001};
        vecs[9]  = '{"slt_eq",     32'h0000_0007, 32'h0000_0007, r_insn(T_SLT, 3, 1, 2), 32'h0000_0000};
        vecs[10] = '{"addi_m1",    32'h0000_0000, 32'h0,  i_insn(T_ADDI, 1, 3, 16'hFFFF), 32'hFFFF_FFFF};
        vecs[11] = '{"addi_ovf",   32'h7FFF_8001, 32'h0,  i_insn(T_ADDI, 1, 3, 16'h7FFF), 32'h8000_0000};
        vecs[12] = '{"addi_min",   32'h0001_0000, 32'h0,  i_insn(T_ADDI, 1, 3, 16'h8000), 32'h0000_8000};

        // ALU vectors: load operands, compute into $3, store $3, halt.
        foreach (vecs[v]) begin
            apply_reset(vecs[v].name);
            fetch_waits = $urandom_range(0, 2);
            data_waits  = $urandom_range(0, 2);
            mem[0] = i_insn(T_LW, 0, 1, 16'h0200);
            mem[1] = i_insn(T_LW, 0, 2, 16'h0204);
            mem[2] = vecs[v].insn;
            mem[3] = i_insn(T_SW, 0, 3, 16'h0208);
            mem[4] = T_HALT;
            mem[32'h200 >> 2] = vecs[v].a;
            mem[32'h204 >> 2] = vecs[v].b;
            exp_q.push_back('{32'h208, vecs[v].expect_val});
            release_reset();
            run_until_halt(vecs[v].name, 400);
            check({vecs[v].name, "_retires"}, 32'(retire_cyc.size()), 32'd4);
            check({vecs[v].name, "_req_idle"}, {31'b0, mem_req}, 32'd0);
            check({vecs[v].name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        end

        // Zero-wait fetches, three wait cycles on every data request.
        apply_reset("seq1");
        fetch_waits = 0;
        data_waits  = 3;
        mem[0]  = i_insn(T_ADDI, 0, 1, 16'd5);
        mem[1]  = i_insn(T_ADDI, 0, 2, 16'hFFFD);
        mem[2]  = r_insn(T_ADD, 3, 1, 2);
        mem[3]  = i_insn(T_SW, 0, 3, 16'h0008);
        mem[4]  = i_insn(T_LW, 0, 4, 16'h0008);
        mem[5]  = r_insn(T_SLT, 5, 2, 1);
        mem[6]  = i_insn(T_ADDI, 0, 0, 16'd7);
        mem[7]  = i_insn(T_SW, 0, 4, 16'h0204);
        mem[8]  = i_insn(T_SW, 0, 5, 16'h0208);
        mem[9]  = i_insn(T_SW, 0, 0, 16'h020C);
        mem[10] = T_HALT;
        exp_q.push_back('{32'h008, 32'd2});
        exp_q.push_back('{32'h204, 32'd2});
        exp_q.push_back('{32'h208, 32'd1});
        exp_q.push_back('{32'h20C, 32'd0});
        seq1_int = '{4, 4, 7, 8, 4, 4, 7, 7, 7};
        release_reset();
        run_until_halt("seq1", 400);
        check("seq1_retires", 32'(retire_cyc.size()), 32'd10);
        for (int i = 0; i < 9; i++) check($sformatf("seq1_interval%0d", i + 1), 32'(interval(i)), 32'(seq1_int[i]));
        check("seq1_sb_empty", 32'(exp_q.size()), 32'd0);

        // Branches and jumps; settles in a beq self-loop at 0x10.
        apply_reset("seq3");
        fetch_waits = 0;
        data_waits  = 0;
        mem[0]     = i_insn(T_ADDI, 0, 1, 16'd5);
        mem[1]     = i_insn(T_ADDI, 0, 2, 16'hFFFD);
        mem[2]     = j_insn(26'h40);
        mem[3]     = T_HALT;
        mem[4]     = i_insn(T_BEQ, 1, 1, 16'hFFFF);
        mem[8'h40] = i_insn(T_BEQ, 1, 2, 16'd5);
        mem[8'h41] = j_insn(26'h4);
        mem[8'h46] = T_HALT;
        seq3_pc  = '{32'h4, 32'h8, 32'h100, 32'h104, 32'h10, 32'h10, 32'h10};
        seq3_int = '{4, 2, 3, 2, 3, 3};
        release_reset();
        run_cycles(40);
        check("seq3_running", {31'b0, halted}, 32'd0);
        for (int i = 0; i < 7; i++)
            check($sformatf("seq3_pc%0d", i), (i < retire_pc.size()) ? retire_pc[i] : 32'hDEAD_BEEF, seq3_pc[i]);
        for (int i = 0; i < 6; i++) check($sformatf("seq3_interval%0d", i + 1), 32'(interval(i)), 32'(seq3_int[i]));

        // Misaligned load and illegal encodings: halt with no further request or retire.
        bad_insn[0] = i_insn(T_LW, 1, 2, 16'h0004);
        bad_insn[1] = 32'hFC00_0000;
        bad_insn[2] = r_insn(6'h21, 3, 1, 2);
        bad_name    = '{"halt_misaligned", "halt_op3f", "halt_funct21"};
        for (int k = 0; k < 3; k++) begin
            apply_reset(bad_name[k]);
            mem[0] = i_insn(T_ADDI, 0, 1, 16'd2);
            mem[1] = bad_insn[k];
            mem[2] = i_insn(T_SW, 0, 1, 16'h0200);
            release_reset();
            run_until_halt(bad_name[k], 100);
            run_cycles(5);
            check({bad_name[k], "_retires"}, 32'(retire_cyc.size()), 32'd1);
            check({bad_name[k], "_xfers"}, 32'(xfers), 32'd2);
            check({bad_name[k], "_req_low"}, {31'b0, mem_req}, 32'd0);
            check({bad_name[k], "_sticky"}, {31'b0, halted}, 32'd1);
        end

        // Reset while a store waits for ready; afterwards registers read back as zero.
        apply_reset("seq5a");
        fetch_waits = 0;
        data_waits  = 50;
        mem[0] = i_insn(T_ADDI, 0, 1, 16'd9);
        mem[1] = i_insn(T_SW, 0, 1, 16'h0200);
        release_reset();
        begin
            bit seen = 0;
            for (int i = 0; i < 60 && !seen; i++) begin
                @(posedge clk);
                #1;
                seen = mem_req && mem_we;
            end
            check("seq5_store_pending", {31'b0, seen}, 32'd1);
        end
        apply_reset("seq5b");
        data_waits = 0;
        mem[0] = i_insn(T_SW, 0, 1, 16'h0204);
        mem[1] = T_HALT;
        exp_q.push_back('{32'h204, 32'd0});
        release_reset();
        run_until_halt("seq5", 100);
        check("seq5_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
